// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM state encodings,
// and the byte-enable / alignment helpers used by the top and the lane aligner.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
    function automatic logic [3:0] byte_enable(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << {lane[1], 1'b0};
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables on the way out,
// lane extraction plus sign/zero extension of read data on the way back.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DataSize = 32
) (
    input  size_e               size,
    input  logic                is_signed,
    input  logic [1:0]          lane,
    input  logic [DataSize-1:0] wdata,
    input  logic [DataSize-1:0] rdata,
    output logic [3:0]          be,
    output logic [DataSize-1:0] wdata_rep,
    output logic [DataSize-1:0] rdata_ext
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before the case,
        // otherwise an uncovered branch would infer a latch.
        be        = byte_enable(size, lane);
        wdata_rep = wdata;
        rdata_ext = rdata;
        lane_byte = rdata[{lane, 3'b000} +: 8];
        lane_half = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{(DataSize-8){is_signed & lane_byte[7]}}, lane_byte};
            end
            SZ_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{(DataSize-16){is_signed & lane_half[15]}}, lane_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: one transaction at a time over a req/ack bus, stalling the core
// while busy. Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DataSize      = 32,
    parameter int AddrWidth     = 16,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ls_valid,
    input  logic                 ls_write,
    input  logic [1:0]           ls_size,
    input  logic                 ls_signed,
    input  logic [DataSize-1:0]  ls_addr,
    input  logic [DataSize-1:0]  ls_wdata,
    output logic                 ls_stall,
    output logic                 ls_done,
    output logic                 ls_error,
    output logic [DataSize-1:0]  mem_read_data,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [AddrWidth-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [DataSize-1:0]  bus_wdata,
    input  logic                 bus_ack,
    input  logic [DataSize-1:0]  bus_rdata
);

    if (DataSize != 32) begin : g_bad_width
        $error("load_store_unit supports DataSize = 32 only");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("load_store_unit needs TimeoutCycles >= 1");
    end

    state_e     state;
    size_e      op_size;
    logic       op_signed;
    logic [1:0] op_lane;

    size_e               req_size;
    logic                req_misaligned;
    size_e               al_size;
    logic                al_signed;
    logic [1:0]          al_lane;
    logic [3:0]          al_be;
    logic [DataSize-1:0] al_wdata;
    logic [DataSize-1:0] al_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^ls_addr[DataSize-1:AddrWidth];

    assign req_size       = size_e'(ls_size);
    assign req_misaligned = misaligned(req_size, ls_addr[1:0]);
    assign ls_stall       = (state == ST_IDLE && ls_valid) || (state == ST_REQ);

    // The aligner serves the incoming request in IDLE and the captured op while waiting for data.
    assign al_size   = (state == ST_IDLE) ? req_size     : op_size;
    assign al_signed = (state == ST_IDLE) ? ls_signed    : op_signed;
    assign al_lane   = (state == ST_IDLE) ? ls_addr[1:0] : op_lane;

    lsu_lane_align #(
        .DataSize (DataSize)
    ) u_lane_align (
        .size      (al_size),
        .is_signed (al_signed),
        .lane      (al_lane),
        .wdata     (ls_wdata),
        .rdata     (bus_rdata),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int TimerW = $clog2(TimeoutCycles + 1);
    logic [TimerW-1:0] timer;
`endif

    // NOTE: the asynchronous reset clears bus_req immediately, so a transaction in flight is
    // abandoned without waiting for a clock edge; any ack arriving afterwards finds IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_size       <= SZ_BYTE;
            op_signed     <= 1'b0;
            op_lane       <= 2'b00;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_be        <= 4'b0000;
            bus_wdata     <= '0;
            ls_done       <= 1'b0;
            ls_error      <= 1'b0;
            mem_read_data <= '0;
`ifdef LSU_TIMEOUT_EN
            timer         <= '0;
`endif
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples the
            // pre-edge values; the pulse defaults below are overridden on entry to DONE.
            ls_done  <= 1'b0;
            ls_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ls_valid) begin
                        if (req_misaligned) begin
                            state    <= ST_DONE;
                            ls_done  <= 1'b1;
                            ls_error <= 1'b1;
                        end else begin
                            op_size   <= req_size;
                            op_signed <= ls_signed;
                            op_lane   <= ls_addr[1:0];
                            bus_req   <= 1'b1;
                            bus_we    <= ls_write;
                            bus_addr  <= {ls_addr[AddrWidth-1:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                            state     <= ST_REQ;
`ifdef LSU_TIMEOUT_EN
                            timer     <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            mem_read_data <= al_rdata;
                        end
                        state   <= ST_DONE;
                        ls_done <= 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (timer == TimerW'(TimeoutCycles - 1)) begin
                        bus_req  <= 1'b0;
                        state    <= ST_DONE;
                        ls_done  <= 1'b1;
                        ls_error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboarded load/store transactions against a
// responding bus model, plus reset-abort and no-ack scenarios.
module tb_load_store_unit;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_write, ls_signed;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_stall, ls_done, ls_error;
    logic [31:0] mem_read_data;
    logic        bus_req, bus_we, bus_ack;
    logic [15:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;

    load_store_unit #(
        .DataSize      (32),
        .AddrWidth     (16),
        .TimeoutCycles (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ls_valid      (ls_valid),
        .ls_write      (ls_write),
        .ls_size       (ls_size),
        .ls_signed     (ls_signed),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_stall      (ls_stall),
        .ls_done       (ls_done),
        .ls_error      (ls_error),
        .mem_read_data (mem_read_data),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, act, exp);
        end
    endtask

    // Bus responder: acks during the Nth cycle of bus_req (0 = never), records what it saw.
    int          ack_delay = 1;
    int          req_cycles = 0;
    logic        force_ack = 1'b0;
    logic        bus_unstable = 1'b0;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    always @(posedge clk) begin
        #1;
        if (bus_req) begin
            req_cycles++;
            if (req_cycles == 1) begin
                cap_we = bus_we; cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
            end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_be !== cap_be ||
                         bus_wdata !== cap_wdata) begin
                bus_unstable = 1'b1;
            end
            bus_ack = force_ack | (ack_delay != 0 && req_cycles == ack_delay);
        end else begin
            bus_ack = force_ack;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic        bus;
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_load = 32'h0;

    task automatic do_op(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int delay);
        exp_t        e, g;
        logic        mis, tmo;
        logic [31:0] sh, ext;
        int          cycles, stall;
        bit          done;
        logic        got_err;
        logic [31:0] got_rd;

        mis = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        tmo = !mis && delay == 0;
        e.bus   = !mis;
        e.we    = wr;
        e.addr  = {addr[15:2], 2'b00};
        e.err   = mis || tmo;
        case (sz)
            2'b00: begin
                e.be    = 4'b0001 << addr[1:0];
                e.wdata = {4{wd[7:0]}};
                sh      = rd >> (8 * int'(addr[1:0]));
                ext     = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            end
            2'b01: begin
                e.be    = addr[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{wd[15:0]}};
                sh      = rd >> (16 * int'(addr[1]));
                ext     = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            end
            default: begin
                e.be    = 4'b1111;
                e.wdata = wd;
                ext     = rd;
            end
        endcase
        if (!mis && !wr && !tmo) last_load = ext;
        e.rdata = last_load;
        e.reqs  = mis ? 0 : (tmo ? TMO : delay);
        e.stall = e.reqs + 1;
        e.lat   = e.stall + 1;
        sb_q.push_back(e);

        @(posedge clk); #1;
        ls_valid = 1'b1; ls_write = wr; ls_size = sz; ls_signed = sgn;
        ls_addr = addr; ls_wdata = wd; bus_rdata = rd;
        ack_delay = delay; req_cycles = 0; bus_unstable = 1'b0;

        cycles = 0; stall = 0; done = 0; got_err = 1'b0; got_rd = 32'h0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (ls_stall) stall++;
            if (ls_done) begin
                done = 1; got_err = ls_error; got_rd = mem_read_data;
            end else begin
                @(posedge clk); #1;
                ls_valid = 1'b0;
            end
        end
        ls_valid = 1'b0;

        g = sb_q.pop_front();
        check({tag, "/done_seen"}, 32'(done), 32'd1);
        check({tag, "/latency"}, cycles, g.lat);
        check({tag, "/stall_cycles"}, stall, g.stall);
        check({tag, "/error"}, 32'(got_err), 32'(g.err));
        check({tag, "/mem_read_data"}, got_rd, g.rdata);
        check({tag, "/req_cycles"}, req_cycles, g.reqs);
        if (g.bus) begin
            check({tag, "/bus_we"}, 32'(cap_we), 32'(g.we));
            check({tag, "/bus_addr"}, 32'(cap_addr), 32'(g.addr));
            check({tag, "/bus_be"}, 32'(cap_be), 32'(g.be));
            check({tag, "/bus_wdata"}, cap_wdata, g.wdata);
            check({tag, "/bus_stable"}, 32'(bus_unstable), 32'd0);
        end
        @(negedge clk);
        check({tag, "/done_one_cycle"}, {30'h0, ls_done, ls_error}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
        ls_addr = 32'h0; ls_wdata = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/bus_req", 32'(bus_req), 32'd0);
        check("reset/bus_we", 32'(bus_we), 32'd0);
        check("reset/done_err", {30'h0, ls_done, ls_error}, 32'h0);
        check("reset/bus_addr", 32'(bus_addr), 32'h0);
        check("reset/bus_be", 32'(bus_be), 32'h0);
        check("reset/bus_wdata", bus_wdata, 32'h0);
        check("reset/mem_read_data", mem_read_data, 32'h0);
        check("reset/stall", 32'(ls_stall), 32'd0);
        rst_n = 1'b1;

        do_op("sw_word",     1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
        do_op("lb_signed",   1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_1234, 1);
        do_op("lbu",         1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_1234, 1);
        do_op("lh_wait5",    1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 5);
        do_op("lhu_wait5",   1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'h0, 32'h8001_7FFF, 5);
        do_op("lw_misalign", 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h1111_1111, 1);
        do_op("sb_lane1",    1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00A5, 32'h0, 2);
        do_op("sh_lane1",    1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_BEEF, 32'h0, 1);
        do_op("size_ill",    1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h2222_2222, 1);
        do_op("lh_odd",      1'b0, 2'b01, 1'b1, 32'h0000_0005, 32'h0, 32'h3333_3333, 1);
        do_op("lw_wait3",    1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 3);
        do_op("lb_pos_hi",   1'b0, 2'b00, 1'b1, 32'h0001_0044, 32'h0, 32'h1234_567F, 1);

        // Abort a transaction with reset, then present a late ack.
        @(posedge clk); #1;
        ls_valid = 1'b1; ls_write = 1'b0; ls_size = 2'b10; ls_addr = 32'h40;
        ack_delay = 0; req_cycles = 0;
        @(posedge clk); #1;
        ls_valid = 1'b0;
        check("rst_abort/req_up", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_abort/req_dropped", 32'(bus_req), 32'd0);
        force_ack = 1'b1; bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_abort/no_done", {29'h0, ls_done, bus_req, ls_stall}, 32'h0);
        end
        force_ack = 1'b0; bus_ack = 1'b0;
        last_load = 32'h0;
        check("rst_abort/mem_cleared", mem_read_data, 32'h0);
        do_op("after_reset", 1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0, 32'hABCD_0123, 1);

`ifdef LSU_TIMEOUT_EN
        do_op("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h5555_5555, 0);
`else
        // Without the timeout, a missing ack holds the pipeline until reset.
        @(posedge clk); #1;
        ls_valid = 1'b1; ls_write = 1'b0; ls_size = 2'b10; ls_addr = 32'h80;
        ack_delay = 0; req_cycles = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ls_stall && !ls_done) cnt++;
            @(posedge clk); #1;
            ls_valid = 1'b0;
        end
        check("no_ack/stall_held", cnt, 32'd20);
        check("no_ack/req_held", 32'(bus_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_load = 32'h0;
`endif

        for (int i = 0; i < 24; i++) begin
            do_op("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom & 32'h0001_FFFF, $urandom, $urandom,
                  $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
